// File: rtl/frame_bank_ctrl.sv
// N-bank frame-buffer controller: the decoder fills banks in rotation while the
// display reads full banks, repeating the current frame when no newer bank is ready.
module frame_bank_ctrl #(
  parameter int NUM_BANKS        = 2,
  parameter int PIXELS_PER_FRAME = 76800,
  parameter int ADDR_W           = $clog2(PIXELS_PER_FRAME),
  parameter int BANK_W           = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 CLK_40,
  input  logic                 reset_n,
  input  logic                 init,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [BANK_W-1:0]    wr_bank,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic                 wr_drop,
  input  logic                 rd_en,
  output logic [BANK_W-1:0]    rd_bank,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_frame_start,
  output logic                 frame_repeat,
  output logic [NUM_BANKS-1:0] bank_full,
  output logic                 running
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS_PER_FRAME - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic                   wr_acc;
  logic                   wr_last;
  logic                   rd_act;
  logic                   rd_last;
  logic                   swap;
  logic [BANK_W-1:0]      wr_bank_nx;
  logic [BANK_W-1:0]      rd_bank_nx;
  logic [NUM_BANKS-1:0]   bank_full_nx;

  assign wr_ready   = (state != IDLE) && !bank_full[wr_bank];
  assign wr_acc     = wr_valid && wr_ready;
  assign wr_last    = wr_acc && (wr_addr == LAST_ADDR);
  assign rd_act     = (state == RUN) && rd_en;
  assign rd_last    = rd_act && (rd_addr == LAST_ADDR);
  assign wr_bank_nx = (wr_bank == LAST_BANK) ? '0 : wr_bank + BANK_W'(1);
  assign rd_bank_nx = (rd_bank == LAST_BANK) ? '0 : rd_bank + BANK_W'(1);
  // A single-bank build has no other bank to move to, so it always repeats.
  assign swap       = rd_last && bank_full[rd_bank_nx] && (rd_bank_nx != rd_bank);
  assign running    = (state == RUN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (init) state_nx = FILL;
      FILL:    if (wr_last) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Release and fill never target the same bank: the writer is stalled on rd_bank.
  always_comb begin
    bank_full_nx = bank_full;
    if (swap)    bank_full_nx[rd_bank] = 1'b0;
    if (wr_last) bank_full_nx[wr_bank] = 1'b1;
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr        <= '0;
      wr_bank        <= '0;
      rd_addr        <= '0;
      rd_bank        <= '0;
      bank_full      <= '0;
      wr_drop        <= 1'b0;
      rd_frame_start <= 1'b0;
      frame_repeat   <= 1'b0;
    end else begin
      if (wr_acc) wr_addr <= wr_last ? '0 : wr_addr + ADDR_W'(1);
      if (wr_last) wr_bank <= wr_bank_nx;
      if (rd_act) rd_addr <= rd_last ? '0 : rd_addr + ADDR_W'(1);
      if (swap) rd_bank <= rd_bank_nx;
      bank_full      <= bank_full_nx;
      wr_drop        <= wr_valid && !wr_ready;
      rd_frame_start <= rd_last || ((state == FILL) && wr_last);
      frame_repeat   <= rd_last && !swap;
    end
  end

endmodule

// File: tb/tb_frame_bank_ctrl.sv
// Directed bench for frame_bank_ctrl: a 2-bank and a 3-bank instance with
// 4-pixel frames, driven through fill, swap, repeat, collision and reset cases.
module tb_frame_bank_ctrl;
  localparam int PPF = 4;

  logic       CLK_40 = 1'b0;
  logic       reset_n;

  logic       init_a, wr_valid_a, rd_en_a;
  logic       wr_ready_a, wr_drop_a, rd_frame_start_a, frame_repeat_a, running_a;
  logic [0:0] wr_bank_a, rd_bank_a;
  logic [1:0] wr_addr_a, rd_addr_a, bank_full_a;

  logic       init_b, wr_valid_b, rd_en_b;
  logic       wr_ready_b, wr_drop_b, rd_frame_start_b, frame_repeat_b, running_b;
  logic [1:0] wr_bank_b, rd_bank_b, wr_addr_b, rd_addr_b;
  logic [2:0] bank_full_b;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fr_cnt;

  always #5 CLK_40 = ~CLK_40;

  frame_bank_ctrl #(.NUM_BANKS(2), .PIXELS_PER_FRAME(PPF)) dut_a (
    .CLK_40(CLK_40), .reset_n(reset_n), .init(init_a),
    .wr_valid(wr_valid_a), .wr_ready(wr_ready_a), .wr_bank(wr_bank_a),
    .wr_addr(wr_addr_a), .wr_drop(wr_drop_a), .rd_en(rd_en_a),
    .rd_bank(rd_bank_a), .rd_addr(rd_addr_a), .rd_frame_start(rd_frame_start_a),
    .frame_repeat(frame_repeat_a), .bank_full(bank_full_a), .running(running_a)
  );

  frame_bank_ctrl #(.NUM_BANKS(3), .PIXELS_PER_FRAME(PPF)) dut_b (
    .CLK_40(CLK_40), .reset_n(reset_n), .init(init_b),
    .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_bank(wr_bank_b),
    .wr_addr(wr_addr_b), .wr_drop(wr_drop_b), .rd_en(rd_en_b),
    .rd_bank(rd_bank_b), .rd_addr(rd_addr_b), .rd_frame_start(rd_frame_start_b),
    .frame_repeat(frame_repeat_b), .bank_full(bank_full_b), .running(running_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_40);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    init_a = 1'b0; wr_valid_a = 1'b0; rd_en_a = 1'b0;
    init_b = 1'b0; wr_valid_b = 1'b0; rd_en_b = 1'b0;
    cyc(2);
    chk("rst_wr_ready", 32'(wr_ready_a), 32'd0);
    chk("rst_bank_full", 32'(bank_full_a), 32'd0);
    chk("rst_running", 32'(running_a), 32'd0);
    chk("rst_wr_drop", 32'(wr_drop_a), 32'd0);
    reset_n = 1'b1;

    // idle: writes and reads are refused, every offered pixel is reported lost
    wr_valid_a = 1'b1; rd_en_a = 1'b1;
    cyc(1);
    chk("idle_drop1", 32'(wr_drop_a), 32'd1);
    chk("idle_ready", 32'(wr_ready_a), 32'd0);
    cyc(1);
    chk("idle_drop2", 32'(wr_drop_a), 32'd1);
    chk("idle_rd_addr", 32'(rd_addr_a), 32'd0);
    chk("idle_full", 32'(bank_full_a), 32'd0);
    wr_valid_a = 1'b0; rd_en_a = 1'b0;

    // fill bank 0 and start
    init_a = 1'b1;
    cyc(1);
    init_a = 1'b0;
    chk("fill_running", 32'(running_a), 32'd0);
    chk("fill_ready", 32'(wr_ready_a), 32'd1);
    chk("fill_drop_clear", 32'(wr_drop_a), 32'd0);
    wr_valid_a = 1'b1;
    cyc(2);
    chk("fill_wr_addr", 32'(wr_addr_a), 32'd2);
    chk("fill_rd_addr", 32'(rd_addr_a), 32'd0);
    cyc(2);
    chk("start_full", 32'(bank_full_a), 32'b01);
    chk("start_wr_bank", 32'(wr_bank_a), 32'd1);
    chk("start_wr_addr", 32'(wr_addr_a), 32'd0);
    chk("start_running", 32'(running_a), 32'd1);
    chk("start_frame_start", 32'(rd_frame_start_a), 32'd1);
    chk("start_rd_bank", 32'(rd_bank_a), 32'd0);

    // fill bank 1, then the writer stalls on bank 0
    cyc(1);
    chk("start_pulse_end", 32'(rd_frame_start_a), 32'd0);
    cyc(3);
    chk("pp_full", 32'(bank_full_a), 32'b11);
    chk("pp_wr_bank", 32'(wr_bank_a), 32'd0);
    chk("pp_stall", 32'(wr_ready_a), 32'd0);
    cyc(1);
    chk("pp_stall_drop", 32'(wr_drop_a), 32'd1);
    wr_valid_a = 1'b0;

    // read one frame: swap to bank 1 releases bank 0
    rd_en_a = 1'b1;
    cyc(3);
    chk("pp_rd_addr3", 32'(rd_addr_a), 32'd3);
    chk("pp_rd_bank_hold", 32'(rd_bank_a), 32'd0);
    cyc(1);
    chk("swap_rd_bank", 32'(rd_bank_a), 32'd1);
    chk("swap_full", 32'(bank_full_a), 32'b10);
    chk("swap_frame_start", 32'(rd_frame_start_a), 32'd1);
    chk("swap_no_repeat", 32'(frame_repeat_a), 32'd0);
    chk("swap_ready", 32'(wr_ready_a), 32'd1);
    chk("swap_rd_addr", 32'(rd_addr_a), 32'd0);

    // starvation: two more frames with no new bank
    fr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      fr_cnt += int'(frame_repeat_a);
      if (i == 2) chk("starve_rd_addr3", 32'(rd_addr_a), 32'd3);
      if (i == 3) begin
        chk("starve_wrap", 32'(rd_addr_a), 32'd0);
        chk("starve_repeat", 32'(frame_repeat_a), 32'd1);
        chk("starve_frame_start", 32'(rd_frame_start_a), 32'd1);
      end
    end
    chk("starve_repeat_count", 32'(fr_cnt), 32'd2);
    chk("starve_rd_bank", 32'(rd_bank_a), 32'd1);
    chk("starve_full", 32'(bank_full_a), 32'b10);

    // asynchronous reset in the middle of a frame
    cyc(1);
    chk("mid_rd_addr", 32'(rd_addr_a), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_running", 32'(running_a), 32'd0);
    chk("arst_full", 32'(bank_full_a), 32'd0);
    chk("arst_rd_addr", 32'(rd_addr_a), 32'd0);
    chk("arst_rd_bank", 32'(rd_bank_a), 32'd0);
    chk("arst_wr_bank", 32'(wr_bank_a), 32'd0);
    chk("arst_wr_ready", 32'(wr_ready_a), 32'd0);
    rd_en_a = 1'b0;
    #2;
    reset_n = 1'b1;
    cyc(1);
    init_a = 1'b1;
    cyc(1);
    init_a = 1'b0;
    chk("refill_ready", 32'(wr_ready_a), 32'd1);
    chk("refill_running", 32'(running_a), 32'd0);
    wr_valid_a = 1'b1;
    cyc(4);
    wr_valid_a = 1'b0;
    chk("refill_full", 32'(bank_full_a), 32'b01);
    chk("refill_running_up", 32'(running_a), 32'd1);

    // 3 banks: bank 1 completes on the same edge bank 0 ends its frame
    init_b = 1'b1;
    cyc(1);
    init_b = 1'b0;
    wr_valid_b = 1'b1;
    cyc(4);
    chk("b_start_full", 32'(bank_full_b), 32'b001);
    rd_en_b = 1'b1;
    cyc(4);
    chk("b_coll_repeat", 32'(frame_repeat_b), 32'd1);
    chk("b_coll_frame_start", 32'(rd_frame_start_b), 32'd1);
    chk("b_coll_rd_bank", 32'(rd_bank_b), 32'd0);
    chk("b_coll_full", 32'(bank_full_b), 32'b011);
    chk("b_coll_wr_bank", 32'(wr_bank_b), 32'd2);
    wr_valid_b = 1'b0;
    cyc(4);
    chk("b_swap_rd_bank", 32'(rd_bank_b), 32'd1);
    chk("b_swap_full", 32'(bank_full_b), 32'b010);
    chk("b_swap_no_repeat", 32'(frame_repeat_b), 32'd0);
    chk("b_swap_frame_start", 32'(rd_frame_start_b), 32'd1);
    rd_en_b = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
